// File: rtl/snake_body_engine_if.sv
// snake_body_engine_if: move/steer/apple-candidate inputs, scan-pixel query and game status of the snake engine
interface snake_body_engine_if #(
    parameter int LW = 5
);
    logic          tick;
    logic [3:0]    dir_req;
    logic [9:0]    rand_x;
    logic [9:0]    rand_y;
    logic [9:0]    pix_x;
    logic [9:0]    pix_y;
    logic          pix_head;
    logic          pix_body;
    logic          pix_apple;
    logic          pix_wall;
    logic [LW-1:0] length;
    logic [7:0]    score;
    logic          game_over;

    modport master (
        output tick, dir_req, rand_x, rand_y, pix_x, pix_y,
        input  pix_head, pix_body, pix_apple, pix_wall, length, score, game_over
    );

    modport slave (
        input  tick, dir_req, rand_x, rand_y, pix_x, pix_y,
        output pix_head, pix_body, pix_apple, pix_wall, length, score, game_over
    );
endinterface

// File: rtl/snake_body_engine.sv
// snake_body_engine: snake body shift register, steering, growth/collision FSM, apple placement and per-pixel cell classifier
module snake_body_engine #(
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int CELL_LOG2 = 4,
    parameter int MAX_LEN   = 16,
    parameter int INIT_LEN  = 3
) (
    input logic clk,
    input logic reset,
    snake_body_engine_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PLACE = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;
    localparam logic [3:0] D_L = 4'b0001;
    localparam logic [3:0] D_R = 4'b0010;
    localparam logic [3:0] D_U = 4'b0100;
    localparam logic [3:0] D_D = 4'b1000;
    localparam logic [9:0] X_MAX = 10'(GRID_W - 1);
    localparam logic [9:0] Y_MAX = 10'(GRID_H - 1);

    function automatic logic is_wall(logic [9:0] x, logic [9:0] y);
        return x == '0 || x == X_MAX || y == '0 || y == Y_MAX;
    endfunction

    function automatic logic is_interior(logic [9:0] x, logic [9:0] y);
        return x != '0 && x < X_MAX && y != '0 && y < Y_MAX;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [3:0]    dir_q, dir_d;
    logic [3:0]    last_dir_q, last_dir_d;
    logic [9:0]    seg_x_q [MAX_LEN];
    logic [9:0]    seg_x_d [MAX_LEN];
    logic [9:0]    seg_y_q [MAX_LEN];
    logic [9:0]    seg_y_d [MAX_LEN];
    logic [9:0]    apple_x_q, apple_x_d;
    logic [9:0]    apple_y_q, apple_y_d;
    logic [LW-1:0] len_q, len_d;
    logic [7:0]    score_q, score_d;
    logic [3:0]    flags_q, flags_d;

    logic [3:0] rev;
    logic       dir_ok;
    logic [9:0] nx, ny;
    logic       grow, hit, moving, placed;
    logic [9:0] cx, cy;
    logic       in_grid, on_head, on_body, on_apple, on_wall;

    // Game step: steering, head advance with wall/self collision, growth and apple placement
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        last_dir_d = last_dir_q;
        seg_x_d    = seg_x_q;
        seg_y_d    = seg_y_q;
        apple_x_d  = apple_x_q;
        apple_y_d  = apple_y_q;
        len_d      = len_q;
        score_d    = score_q;
        rev    = {last_dir_q[2], last_dir_q[3], last_dir_q[0], last_dir_q[1]};
        dir_ok = (bus.dir_req == D_L || bus.dir_req == D_R || bus.dir_req == D_U || bus.dir_req == D_D)
                 && bus.dir_req != rev && state_q != S_OVER;
        nx = dir_q[0] ? seg_x_q[0] - 10'd1 : dir_q[1] ? seg_x_q[0] + 10'd1 : seg_x_q[0];
        ny = dir_q[2] ? seg_y_q[0] - 10'd1 : dir_q[3] ? seg_y_q[0] + 10'd1 : seg_y_q[0];
        grow = state_q == S_RUN && nx == apple_x_q && ny == apple_y_q;
        hit  = is_wall(nx, ny);
        // The tail cell is vacated by the same move unless the snake grows
        for (int k = 1; k < MAX_LEN; k++)
            if (LW'(k) < len_q && (LW'(k) != len_q - 1'b1 || grow) && seg_x_q[k] == nx && seg_y_q[k] == ny)
                hit = 1'b1;
        moving = bus.tick && (state_q == S_RUN || state_q == S_PLACE);
        placed = state_q == S_PLACE && is_interior(bus.rand_x, bus.rand_y)
                 && !(bus.rand_x == seg_x_q[0] && bus.rand_y == seg_y_q[0]);
        if (dir_ok) begin
            dir_d = bus.dir_req;
            if (state_q == S_IDLE)
                state_d = S_RUN;
        end
        if (placed && !(moving && hit)) begin
            apple_x_d = bus.rand_x;
            apple_y_d = bus.rand_y;
            state_d   = S_RUN;
        end
        if (moving && hit) begin
            state_d = S_OVER;
        end else if (moving) begin
            seg_x_d[0] = nx;
            seg_y_d[0] = ny;
            for (int k = 1; k < MAX_LEN; k++) begin
                seg_x_d[k] = seg_x_q[k-1];
                seg_y_d[k] = seg_y_q[k-1];
            end
            last_dir_d = dir_q;
            if (grow) begin
                len_d   = len_q == LW'(MAX_LEN) ? len_q : len_q + 1'b1;
                score_d = score_q == 8'hFF ? score_q : score_q + 8'd1;
                state_d = S_PLACE;
            end
        end
    end

    // Classify the scan pixel's cell with head > body > apple > wall priority
    always_comb begin
        cx       = bus.pix_x >> CELL_LOG2;
        cy       = bus.pix_y >> CELL_LOG2;
        in_grid  = cx <= X_MAX && cy <= Y_MAX;
        on_head  = cx == seg_x_q[0] && cy == seg_y_q[0];
        on_body  = 1'b0;
        for (int k = 1; k < MAX_LEN; k++)
            if (LW'(k) < len_q && cx == seg_x_q[k] && cy == seg_y_q[k])
                on_body = 1'b1;
        on_apple = state_q != S_PLACE && cx == apple_x_q && cy == apple_y_q;
        on_wall  = is_wall(cx, cy);
        flags_d  = !in_grid ? 4'b0000 : on_head ? 4'b1000 : on_body ? 4'b0100 :
                   on_apple ? 4'b0010 : on_wall ? 4'b0001 : 4'b0000;
    end

    // State registers; reset restores the centred, rightward-facing starting snake
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            dir_q      <= D_R;
            last_dir_q <= D_R;
            for (int k = 0; k < MAX_LEN; k++) begin
                seg_x_q[k] <= 10'(GRID_W / 2 - k);
                seg_y_q[k] <= 10'(GRID_H / 2);
            end
            apple_x_q  <= 10'(3 * GRID_W / 4);
            apple_y_q  <= 10'(GRID_H / 2);
            len_q      <= LW'(INIT_LEN);
            score_q    <= 8'd0;
            flags_q    <= 4'b0000;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            last_dir_q <= last_dir_d;
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
            apple_x_q  <= apple_x_d;
            apple_y_q  <= apple_y_d;
            len_q      <= len_d;
            score_q    <= score_d;
            flags_q    <= flags_d;
        end
    end

    assign bus.pix_head  = flags_q[3];
    assign bus.pix_body  = flags_q[2];
    assign bus.pix_apple = flags_q[1];
    assign bus.pix_wall  = flags_q[0];
    assign bus.length    = len_q;
    assign bus.score     = score_q;
    assign bus.game_over = state_q == S_OVER;
endmodule

// File: tb/tb_snake_body_engine.sv
// tb_snake_body_engine: directed scenarios plus randomized play checked against a queue-based snake model
module tb_snake_body_engine;
    localparam int GW = 40;
    localparam int GH = 30;
    localparam int ML = 16;
    localparam int IL = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    snake_body_engine_if #(.LW($clog2(ML + 1))) bus();

    snake_body_engine #(
        .GRID_W(GW), .GRID_H(GH), .CELL_LOG2(4), .MAX_LEN(ML), .INIT_LEN(IL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // model: body as queues (index 0 = head); dir codes 0 L,1 R,2 U,3 D (reverse = code^1)
    // mode 0 idle, 1 run, 2 place, 3 over
    int qx[$];
    int qy[$];
    int m_dir, m_last, m_mode, m_ax, m_ay, m_score;

    function automatic bit wall(int x, int y);
        return x == 0 || x == GW - 1 || y == 0 || y == GH - 1;
    endfunction

    task automatic model_reset();
        qx.delete();
        qy.delete();
        for (int k = 0; k < IL; k++) begin
            qx.push_back(GW / 2 - k);
            qy.push_back(GH / 2);
        end
        m_dir = 1; m_last = 1; m_mode = 0;
        m_ax = 3 * GW / 4; m_ay = GH / 2; m_score = 0;
    endtask

    function automatic logic [3:0] model_flags(int cx, int cy);
        if (cx >= GW || cy >= GH) return 4'b0000;
        if (cx == qx[0] && cy == qy[0]) return 4'b1000;
        for (int i = 1; i < qx.size(); i++)
            if (cx == qx[i] && cy == qy[i]) return 4'b0100;
        if (m_mode != 2 && cx == m_ax && cy == m_ay) return 4'b0010;
        if (wall(cx, cy)) return 4'b0001;
        return 4'b0000;
    endfunction

    task automatic model_step(logic t, logic [3:0] req, int rx, int ry);
        int code, nd, nm, nx, ny, lim;
        bit placed, hit, grow;
        code = req == 4'b0001 ? 0 : req == 4'b0010 ? 1 : req == 4'b0100 ? 2 : req == 4'b1000 ? 3 : -1;
        nd = m_dir;
        nm = m_mode;
        if (code >= 0 && m_mode != 3 && code != (m_last ^ 1)) begin
            nd = code;
            if (m_mode == 0) nm = 1;
        end
        placed = m_mode == 2 && rx >= 1 && rx <= GW - 2 && ry >= 1 && ry <= GH - 2
                 && !(rx == qx[0] && ry == qy[0]);
        if (placed) nm = 1;
        if (t && (m_mode == 1 || m_mode == 2)) begin
            nx = qx[0] + (m_dir == 1 ? 1 : 0) - (m_dir == 0 ? 1 : 0);
            ny = qy[0] + (m_dir == 3 ? 1 : 0) - (m_dir == 2 ? 1 : 0);
            grow = m_mode == 1 && nx == m_ax && ny == m_ay;
            hit = wall(nx, ny);
            lim = grow ? qx.size() : qx.size() - 1;
            for (int i = 1; i < lim; i++)
                if (nx == qx[i] && ny == qy[i]) hit = 1;
            if (hit) begin
                nm = 3;
                placed = 0;
            end else begin
                qx.push_front(nx);
                qy.push_front(ny);
                m_last = m_dir;
                if (grow) begin
                    if (qx.size() > ML) begin
                        void'(qx.pop_back());
                        void'(qy.pop_back());
                    end
                    if (m_score < 255) m_score++;
                    nm = 2;
                end else begin
                    void'(qx.pop_back());
                    void'(qy.pop_back());
                end
            end
        end
        if (placed) begin
            m_ax = rx;
            m_ay = ry;
        end
        m_dir = nd;
        m_mode = nm;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic [3:0] e;
        @(posedge clk);
        e = model_flags(int'(bus.pix_x >> 4), int'(bus.pix_y >> 4));
        model_step(bus.tick, bus.dir_req, int'(bus.rand_x), int'(bus.rand_y));
        #1;
        chk("pix_flags", 32'({bus.pix_head, bus.pix_body, bus.pix_apple, bus.pix_wall}), 32'(e));
        chk("length", 32'(bus.length), 32'(qx.size()));
        chk("score", 32'(bus.score), 32'(m_score));
        chk("game_over", 32'(bus.game_over), 32'(m_mode == 3));
    endtask

    task automatic step(logic t, logic [3:0] req);
        bus.tick = t;
        bus.dir_req = req;
        cyc();
        bus.tick = 1'b0;
        bus.dir_req = 4'b0000;
    endtask

    task automatic look(int cx, int cy);
        bus.pix_x = 10'(cx * 16 + int'($urandom_range(0, 15)));
        bus.pix_y = 10'(cy * 16 + int'($urandom_range(0, 15)));
        step(1'b0, 4'b0000);
    endtask

    task automatic set_rand(int x, int y);
        bus.rand_x = 10'(x);
        bus.rand_y = 10'(y);
    endtask

    task automatic hard_reset();
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
        bus.tick = 1'b0;
        bus.dir_req = 4'b0000;
        chk("reset_flags", 32'({bus.pix_head, bus.pix_body, bus.pix_apple, bus.pix_wall}), 32'd0);
        chk("reset_length", 32'(bus.length), 32'd3);
        chk("reset_score", 32'(bus.score), 32'd0);
        chk("reset_game_over", 32'(bus.game_over), 32'd0);
    endtask

    initial begin
        int x, y;
        bus.tick = 1'b0;
        bus.dir_req = 4'b0000;
        set_rand(0, 5);
        bus.pix_x = 10'd320;
        bus.pix_y = 10'd240;
        hard_reset();
        // pixel classes after reset, including beyond-grid pixels
        look(20, 15); chk("px_head", 32'(bus.pix_head), 32'd1);
        look(19, 15); chk("px_body", 32'(bus.pix_body), 32'd1);
        look(0, 0);   chk("px_wall", 32'(bus.pix_wall), 32'd1);
        look(30, 15); chk("px_apple", 32'(bus.pix_apple), 32'd1);
        look(40, 2);  chk("px_beyond", 32'({bus.pix_head, bus.pix_body, bus.pix_apple, bus.pix_wall}), 32'd0);
        // start right, eat apple on the 10th tick, then apple placement retry
        step(1'b0, 4'b0010);
        for (int i = 0; i < 10; i++) step(1'b1, 4'b0000);
        chk("grow_len", 32'(bus.length), 32'd4);
        chk("grow_score", 32'(bus.score), 32'd1);
        look(30, 15); chk("grow_head", 32'(bus.pix_head), 32'd1);
        look(5, 5);   chk("place_reject", 32'(bus.pix_apple), 32'd0);
        set_rand(5, 5);
        step(1'b0, 4'b0000);
        set_rand(0, 5);
        look(5, 5);   chk("place_accept", 32'(bus.pix_apple), 32'd1);
        // reverse request ignored, perpendicular accepted
        step(1'b0, 4'b0001);
        step(1'b1, 4'b0000);
        look(31, 15); chk("rev_ignored", 32'(bus.pix_head), 32'd1);
        step(1'b0, 4'b0100);
        step(1'b1, 4'b0000);
        look(31, 14); chk("turn_up", 32'(bus.pix_head), 32'd1);
        // length 4 circling a 2x2 loop never collides
        for (int r = 0; r < 2; r++) begin
            step(1'b0, 4'b0001); step(1'b1, 4'b0000);
            step(1'b0, 4'b1000); step(1'b1, 4'b0000);
            step(1'b0, 4'b0010); step(1'b1, 4'b0000);
            step(1'b0, 4'b0100); step(1'b1, 4'b0000);
        end
        chk("loop_alive", 32'(bus.game_over), 32'd0);
        look(31, 14); chk("loop_head", 32'(bus.pix_head), 32'd1);
        // reset coinciding with a growth tick
        hard_reset();
        step(1'b0, 4'b0010);
        for (int i = 0; i < 9; i++) step(1'b1, 4'b0000);
        bus.tick = 1'b1;
        hard_reset();
        step(1'b1, 4'b0000);
        look(20, 15); chk("idle_no_move", 32'(bus.pix_head), 32'd1);
        look(30, 15); chk("idle_apple", 32'(bus.pix_apple), 32'd1);
        // run up into the top wall
        hard_reset();
        step(1'b0, 4'b0100);
        for (int i = 0; i < 14; i++) step(1'b1, 4'b0000);
        look(20, 1);  chk("top_head", 32'(bus.pix_head), 32'd1);
        chk("top_alive", 32'(bus.game_over), 32'd0);
        step(1'b1, 4'b0000);
        chk("wall_over", 32'(bus.game_over), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0000);
        step(1'b0, 4'b0001);
        step(1'b1, 4'b0000);
        look(20, 1);  chk("over_frozen", 32'(bus.pix_head), 32'd1);
        // length 5, tight turn bites the body
        hard_reset();
        step(1'b0, 4'b0010);
        for (int i = 0; i < 10; i++) step(1'b1, 4'b0000);
        set_rand(34, 15);
        step(1'b0, 4'b0000);
        set_rand(0, 5);
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0000);
        chk("len5", 32'(bus.length), 32'd5);
        set_rand(5, 5);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0100); step(1'b1, 4'b0000);
        step(1'b0, 4'b0001); step(1'b1, 4'b0000);
        step(1'b0, 4'b1000); step(1'b1, 4'b0000);
        chk("self_over", 32'(bus.game_over), 32'd1);
        // randomized games
        for (int g = 0; g < 6; g++) begin
            hard_reset();
            for (int c = 0; c < 700; c++) begin
                if ($urandom_range(0, 1) == 0) begin
                    x = qx[0] + int'($urandom_range(0, 6)) - 3;
                    y = qy[0] + int'($urandom_range(0, 6)) - 3;
                end else begin
                    x = int'($urandom_range(0, 44));
                    y = int'($urandom_range(0, 34));
                end
                set_rand(x < 0 ? 0 : x, y < 0 ? 0 : y);
                bus.pix_x = 10'($urandom_range(0, 44) * 16 + $urandom_range(0, 15));
                bus.pix_y = 10'($urandom_range(0, 33) * 16 + $urandom_range(0, 15));
                step($urandom_range(0, 3) == 0,
                     $urandom_range(0, 1) == 0 ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15)));
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/snake_body_engine.md
SNAKE_BODY_ENGINE -- requirements
Module: snake_body_engine

Interface
REQ-001 Parameter GRID_W, default 40, playfield width in cells.
REQ-002 Parameter GRID_H, default 30, playfield height in cells.
REQ-003 Parameter CELL_LOG2, default 4, log2 of cell size in pixels (16 px cells, 640x480).
REQ-004 Parameter MAX_LEN, default 16, maximum snake length in segments (>= INIT_LEN+1).
REQ-005 Parameter INIT_LEN, default 3, snake length after reset.
REQ-006 clk  in  1  single system clock; all state updates on the rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 tick  in  1  one-cycle move strobe; the snake advances one cell per tick.
REQ-009 dir_req  in  4  one-hot direction request: 0001 left, 0010 right, 0100 up, 1000 down; other codes mean no request.
REQ-010 rand_x, rand_y  in  10  free-running random candidate apple cell coordinates.
REQ-011 pix_x, pix_y  in  10  current scan pixel coordinates.
REQ-012 pix_head, pix_body, pix_apple, pix_wall  out  1 each  registered cell-class flags for the scan pixel.
REQ-013 length  out  clog2(MAX_LEN+1)  current length; score out 8 apples eaten; game_over out 1.

Function
REQ-014 States: IDLE, RUN, PLACE, OVER; an encoding is not mandated.
REQ-015 Wall cells: x==0, x==GRID_W-1, y==0, y==GRID_H-1; interior is every other cell.
REQ-016 Body: MAX_LEN (x,y) segment registers; segment 0 is the head; segments >= length are inactive.
REQ-017 Direction register: a valid dir_req loads it on any clock unless it is the exact reverse of the direction used at the last move (reverse ignored); invalid codes ignored.
REQ-018 IDLE: no movement; first accepted dir_req moves the FSM to RUN; tick ignored.
REQ-019 On tick in RUN or PLACE: next head = head +/- 1 cell in the stored direction; segments k shift to k+1.
REQ-020 Growth: next head equals the apple cell in RUN -> length+1 (saturates at MAX_LEN), score+1 (saturates at 255), FSM -> PLACE.
REQ-021 Wall collision: next head on a wall cell -> FSM -> OVER; body, length and score frozen, no shift.
REQ-022 Self collision: next head equals any active segment 1..length-1, excluding segment length-1 when not growing -> OVER, no shift.
REQ-023 Collision takes priority over growth on the same tick.
REQ-024 PLACE: each clock sample rand_x/rand_y; accept if interior and not equal to the current head; accepted -> load apple, FSM -> RUN the next clock; rejected -> retry next clock.
REQ-025 In PLACE the apple is not drawn and cannot be eaten; ticks still move the snake.
REQ-026 OVER: game_over=1; all ticks and dir_req ignored until reset.
REQ-027 Pixel path: cell = pix >> CELL_LOG2; flags valid exactly 1 clk after pix_x/pix_y; pix_head set on segment 0, pix_body on active segments 1..length-1, pix_apple on apple cell (not in PLACE), pix_wall on wall cells; pixels beyond the grid give all flags 0.
REQ-028 Flag priority: head > body > apple > wall; at most one flag high.

Reset
REQ-029 Reset (any state, mid-tick included) loads: FSM IDLE, direction right, head (GRID_W/2, GRID_H/2), segments k=1..INIT_LEN-1 at (GRID_W/2-k, GRID_H/2), length INIT_LEN, score 0, game_over 0.
REQ-030 Reset places the apple at (3*GRID_W/4, GRID_H/2) and clears all pix_* flags to 0; reset dominates tick and dir_req in the same cycle.

Verification
REQ-031 Reset, dir_req=0010, 10 ticks -> head (30,15), length 4, score 1, FSM PLACE; rand (0,5) rejected, then (5,5) accepted -> apple (5,5), RUN.
REQ-032 Moving right, dir_req=0001 -> ignored; next tick head x+1; dir_req=0100 then tick -> head y-1.
REQ-033 From reset, dir_req=0100, 14 ticks -> head (20,1); 15th tick -> game_over=1, head stays (20,1); further ticks no change.
REQ-034 Length 5, moves up,left,down,right on successive ticks -> head enters segment 3 -> OVER; length 4 on a 2x2 loop (tail vacates) -> no collision.
REQ-035 pix_x=320, pix_y=240 after reset -> pix_head=1 next clk; pix (0,0) -> pix_wall=1; pix (480,240) -> pix_apple=1.
REQ-036 reset asserted together with a growth tick -> length 3, score 0, IDLE; no growth applied.
